// File: rtl/coll_dest_sequencer.sv
// coll_dest_sequencer: replicates a collective flit into per-algorithm destination copies
// using a snapshot of a runtime-programmable communicator table.
module coll_dest_sequencer #(
  parameter int PayloadWidth = 32,
  parameter int CoordWidth = 3,
  parameter int RankWidth = 9,
  parameter int CtxEntries = 4,
  parameter int MaxFanout = 8,
  parameter logic [3*CoordWidth-1:0] MyAddr = '0,
  localparam int AddrW = 3*CoordWidth,
  localparam int FanW = $clog2(MaxFanout+1),
  localparam int FlitWidth = PayloadWidth+22+RankWidth+2*AddrW+1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FlitWidth-1:0]          in_flit,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [FlitWidth+FanW-1:0]     out_flit,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic                          cfg_we,
  input  logic [$clog2(CtxEntries)-1:0] cfg_ctx,
  input  logic [$clog2(MaxFanout+3)-1:0] cfg_slot,
  input  logic [RankWidth+2*FanW:0]     cfg_wdata,
  output logic                          err_bad_ctx
);
  localparam int AL = PayloadWidth+4;
  localparam int TG = PayloadWidth+6;
  localparam int CX = PayloadWidth+14;
  localparam int RK = PayloadWidth+22;
  localparam int SR = RK+RankWidth;
  localparam int VB = SR+2*AddrW;
  localparam int CxW = $clog2(CtxEntries);
  localparam int SiW = $clog2(MaxFanout);
  localparam int KW = $clog2(MaxFanout+2);
  localparam int DW = RankWidth+1;
  localparam int LoW = SR+AddrW;
  typedef enum logic {IDLE, EMIT} state_t;
  logic                 r_ev   [CtxEntries];
  logic [RankWidth-1:0] r_lr   [CtxEntries];
  logic [FanW-1:0]      r_nc   [CtxEntries];
  logic [FanW-1:0]      r_lg   [CtxEntries];
  logic [AddrW-1:0]     r_par  [CtxEntries];
  logic [AddrW-1:0]     r_ring [CtxEntries];
  logic [AddrW-1:0]     r_slot [CtxEntries][MaxFanout];
  always_ff @(posedge clk)
    if (rst) begin
      for (int c = 0; c < CtxEntries; c++) begin
        r_ev[c] <= 1'b0;
        r_lr[c] <= '0;
        r_nc[c] <= '0;
        r_lg[c] <= '0;
        r_par[c] <= '0;
        r_ring[c] <= '0;
        for (int s = 0; s < MaxFanout; s++) r_slot[c][s] <= '0;
      end
    end else if (cfg_we) begin
      if (int'(cfg_slot) < MaxFanout) r_slot[cfg_ctx][cfg_slot[SiW-1:0]] <= cfg_wdata[AddrW-1:0];
      else if (int'(cfg_slot) == MaxFanout) r_par[cfg_ctx] <= cfg_wdata[AddrW-1:0];
      else if (int'(cfg_slot) == MaxFanout+1) r_ring[cfg_ctx] <= cfg_wdata[AddrW-1:0];
      else if (int'(cfg_slot) == MaxFanout+2) {r_ev[cfg_ctx], r_lg[cfg_ctx], r_nc[cfg_ctx], r_lr[cfg_ctx]} <= cfg_wdata;
    end
  logic [CxW-1:0]       w_ci;
  logic                 w_ok, w_local, w_ring, w_go, w_bad, w_last, w_use;
  logic [1:0]           w_alg;
  logic [7:0]           w_tag, w_tag_o;
  logic [RankWidth-1:0] w_rk, w_lr, w_rank_o;
  logic [DW-1:0]        w_d;
  logic [AddrW-1:0]     w_fix, w_dst;
  int                   w_nc, w_lg, w_bl, w_base, w_cnt, w_n;
  assign w_ci = in_flit[CX +: CxW];
  assign w_ok = int'(in_flit[CX +: 8]) < CtxEntries && r_ev[w_ci];
  assign w_local = in_flit[SR +: AddrW] == MyAddr;
  assign w_alg = in_flit[AL +: 2];
  assign w_tag = in_flit[TG +: 8];
  assign w_rk = in_flit[RK +: RankWidth];
  assign w_lr = r_lr[w_ci];
  assign w_rank_o = w_local ? w_lr : w_rk;
  assign w_ring = w_alg == 2'd2 && w_tag != 8'd0;
  assign w_tag_o = w_ring ? w_tag - 8'd1 : w_tag;
  assign w_fix = (w_alg == 2'd0 && w_lr != '0) ? r_par[w_ci] : w_ring ? r_ring[w_ci] : MyAddr;
  // copies are: optional leading MyAddr copy (pre), cnt slot copies from base, then r_fix
  always_comb begin
    w_nc = int'(r_nc[w_ci]) > MaxFanout ? MaxFanout : int'(r_nc[w_ci]);
    w_lg = int'(r_lg[w_ci]) > MaxFanout ? MaxFanout : int'(r_lg[w_ci]);
    w_d = w_rk >= w_lr ? {1'b0, w_rk} - {1'b0, w_lr} : {1'b0, w_lr} - {1'b0, w_rk};
    w_bl = 0;
    for (int i = 0; i < DW; i++) w_bl = w_d[i] ? i + 1 : w_bl;
    w_base = (w_alg == 2'd3 && !w_local) ? (w_bl < w_lg ? w_bl : w_lg) : 0;
    w_cnt = w_alg == 2'd1 ? w_nc : w_alg == 2'd3 ? w_lg - w_base : 0;
    w_n = w_alg == 2'd1 ? (w_local ? (w_nc > 0 ? w_nc : 1) : w_nc + 1) :
          w_alg == 2'd3 ? (w_local ? (w_cnt > 0 ? w_cnt : 1) : w_cnt + 1) : 1;
  end
  state_t           r_state, w_nstate;
  logic [KW-1:0]    r_k, w_nk, r_n, r_base, r_cnt, w_j, w_si;
  logic             r_pre, r_err;
  logic [AddrW-1:0] r_fix;
  logic [FanW-1:0]  r_ch;
  logic [LoW-1:0]   r_lo;
  logic [AddrW-1:0] r_wslot [MaxFanout];
  assign w_last = r_state == EMIT && r_k == r_n - 1'b1;
  assign in_ready = !rst && (r_state == IDLE || (out_ready && w_last));
  assign w_go = in_valid && in_ready && in_flit[VB] && w_ok;
  assign w_bad = in_valid && in_ready && in_flit[VB] && !w_ok;
  always_comb begin
    w_nstate = r_state;
    w_nk = r_k;
    if (w_go) begin
      w_nstate = EMIT;
      w_nk = '0;
    end else if (r_state == EMIT && out_ready) begin
      w_nstate = w_last ? IDLE : EMIT;
      w_nk = w_last ? '0 : r_k + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    r_state <= rst ? IDLE : w_nstate;
    r_k <= rst ? '0 : w_nk;
    r_err <= !rst && w_bad;
  end
  always_ff @(posedge clk)
    if (w_go) begin
      r_n <= KW'(w_n);
      r_pre <= w_alg == 2'd1 && !w_local;
      r_base <= KW'(w_base);
      r_cnt <= KW'(w_cnt);
      r_fix <= w_fix;
      r_ch <= FanW'(w_nc);
      r_lo <= {in_flit[SR +: AddrW], w_rank_o, in_flit[CX +: 8], w_tag_o, in_flit[TG-1:0]};
      r_wslot <= r_slot[w_ci];
    end
  assign w_j = r_k - KW'(r_pre);
  assign w_use = r_k >= KW'(r_pre) && w_j < r_cnt;
  assign w_si = r_base + w_j;
  assign w_dst = w_use ? r_wslot[w_si[SiW-1:0]] : r_fix;
  assign out_valid = r_state == EMIT;
  assign out_flit = out_valid ? {r_ch, 1'b1, w_dst, r_lo} : '0;
  assign err_bad_ctx = r_err;
endmodule

// File: tb/tb_coll_dest_sequencer.sv
// tb_coll_dest_sequencer: directed scenarios for the collective destination sequencer.
module tb_coll_dest_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [81:0] in_flit = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [85:0] out_flit;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ctx = '0;
  logic [3:0]  cfg_slot = '0;
  logic [17:0] cfg_wdata = '0;
  logic        err_bad_ctx;
  int vec = 0;
  int miss = 0;

  coll_dest_sequencer dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_we(cfg_we), .cfg_ctx(cfg_ctx), .cfg_slot(cfg_slot), .cfg_wdata(cfg_wdata),
    .err_bad_ctx(err_bad_ctx)
  );

  always #5 clk = ~clk;

  function automatic logic [81:0] mk(input logic v, input logic [8:0] dst, input logic [8:0] src,
                                     input logic [8:0] rank, input logic [7:0] ctx, input logic [7:0] tag,
                                     input logic [1:0] alg, input logic [3:0] op, input logic [31:0] pay);
    return {v, dst, src, rank, ctx, tag, alg, op, pay};
  endfunction

  task automatic cfg(input logic [1:0] c, input logic [3:0] s, input logic [17:0] d);
    cfg_we = 1'b1; cfg_ctx = c; cfg_slot = s; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [81:0] f);
    int t = 0;
    in_flit = f; in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      vec++; miss++;
      $display("FAIL send_timeout in_ready stuck at %b, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    vec++; if (out_flit !== '0) begin miss++; $display("FAIL rst_out_flit got %h exp 0", out_flit); end
    vec++; if (err_bad_ctx !== 1'b0) begin miss++; $display("FAIL rst_err got %b exp 0", err_bad_ctx); end
    vec++; if (in_ready !== 1'b0) begin miss++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    rst = 1'b0;
    @(negedge clk);
    vec++; if (in_ready !== 1'b1) begin miss++; $display("FAIL idle_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_uptree;
    logic [85:0] e;
    cfg(2'd0, 4'd8, 18'(9'o011));
    cfg(2'd0, 4'd10, {1'b1, 4'd3, 4'd3, 9'd5});
    send(mk(1'b1, 9'o777, 9'd0, 9'd7, 8'd0, 8'h55, 2'd0, 4'd3, 32'hdeadbeef));
    e = {4'd3, mk(1'b1, 9'o011, 9'd0, 9'd5, 8'd0, 8'h55, 2'd0, 4'd3, 32'hdeadbeef)};
    vec++; if (out_valid !== 1'b1 || out_flit !== e) begin miss++; $display("FAIL uptree got %b/%h exp 1/%h", out_valid, out_flit, e); end
    @(negedge clk);
    vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL uptree_extra got %b exp 0", out_valid); end
  endtask

  task automatic test_bcast;
    logic [8:0]  dl [4];
    logic [85:0] e;
    dl = '{9'o000, 9'o001, 9'o002, 9'o004};
    cfg(2'd0, 4'd0, 18'(9'o001));
    cfg(2'd0, 4'd1, 18'(9'o002));
    cfg(2'd0, 4'd2, 18'(9'o004));
    send(mk(1'b1, 9'd0, 9'o123, 9'd4, 8'd0, 8'h11, 2'd1, 4'h9, 32'h0badf00d));
    for (int i = 0; i < 4; i++) begin
      e = {4'd3, mk(1'b1, dl[i], 9'o123, 9'd4, 8'd0, 8'h11, 2'd1, 4'h9, 32'h0badf00d)};
      if (i == 1) begin
        out_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
          vec++; if (out_valid !== 1'b1 || out_flit !== e) begin miss++; $display("FAIL bcast_stall%0d got %b/%h exp 1/%h", h, out_valid, out_flit, e); end
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      vec++; if (out_valid !== 1'b1 || out_flit !== e) begin miss++; $display("FAIL bcast_copy%0d got %b/%h exp 1/%h", i, out_valid, out_flit, e); end
      @(negedge clk);
    end
    vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL bcast_extra got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back_ring;
    logic [85:0] e;
    cfg(2'd0, 4'd9, 18'(9'o070));
    send(mk(1'b1, 9'd0, 9'o123, 9'd33, 8'd0, 8'd2, 2'd2, 4'h1, 32'h12345678));
    e = {4'd3, mk(1'b1, 9'o070, 9'o123, 9'd33, 8'd0, 8'd1, 2'd2, 4'h1, 32'h12345678)};
    vec++; if (out_valid !== 1'b1 || out_flit !== e) begin miss++; $display("FAIL ring_hop got %b/%h exp 1/%h", out_valid, out_flit, e); end
    vec++; if (in_ready !== 1'b1) begin miss++; $display("FAIL ring_b2b_ready got %b exp 1", in_ready); end
    send(mk(1'b1, 9'd0, 9'o123, 9'd33, 8'd0, 8'd0, 2'd2, 4'h1, 32'h87654321));
    e = {4'd3, mk(1'b1, 9'o000, 9'o123, 9'd33, 8'd0, 8'd0, 2'd2, 4'h1, 32'h87654321)};
    vec++; if (out_valid !== 1'b1 || out_flit !== e) begin miss++; $display("FAIL ring_end got %b/%h exp 1/%h", out_valid, out_flit, e); end
    @(negedge clk);
    vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL ring_extra got %b exp 0", out_valid); end
  endtask

  task automatic test_recdbl;
    logic [8:0]  src_t [4];
    logic [8:0]  rk_t  [4];
    logic [8:0]  ro_t  [4];
    int          n_t   [4];
    logic [8:0]  d_t   [4][4];
    logic [85:0] e;
    src_t = '{9'o123, 9'o000, 9'o123, 9'o123};
    rk_t  = '{9'd2, 9'd9, 9'd7, 9'd0};
    ro_t  = '{9'd2, 9'd0, 9'd7, 9'd0};
    n_t   = '{2, 3, 1, 4};
    d_t[0] = '{9'o044, 9'o000, 9'o000, 9'o000};
    d_t[1] = '{9'o011, 9'o022, 9'o044, 9'o000};
    d_t[2] = '{9'o000, 9'o000, 9'o000, 9'o000};
    d_t[3] = '{9'o011, 9'o022, 9'o044, 9'o000};
    cfg(2'd1, 4'd0, 18'(9'o011));
    cfg(2'd1, 4'd1, 18'(9'o022));
    cfg(2'd1, 4'd2, 18'(9'o044));
    cfg(2'd1, 4'd10, {1'b1, 4'd3, 4'd0, 9'd0});
    for (int c = 0; c < 4; c++) begin
      send(mk(1'b1, 9'd0, src_t[c], rk_t[c], 8'd1, 8'h3c, 2'd3, 4'h7, 32'(c)));
      for (int i = 0; i < n_t[c]; i++) begin
        e = {4'd0, mk(1'b1, d_t[c][i], src_t[c], ro_t[c], 8'd1, 8'h3c, 2'd3, 4'h7, 32'(c))};
        vec++; if (out_valid !== 1'b1 || out_flit !== e) begin miss++; $display("FAIL rd%0d_copy%0d got %b/%h exp 1/%h", c, i, out_valid, out_flit, e); end
        @(negedge clk);
      end
      vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL rd%0d_extra got %b exp 0", c, out_valid); end
    end
  endtask

  task automatic test_errors;
    logic [7:0] cx [2];
    cx = '{8'd7, 8'd2};
    for (int c = 0; c < 2; c++) begin
      send(mk(1'b1, 9'd0, 9'o123, 9'd1, cx[c], 8'd0, 2'd0, 4'h0, 32'h0));
      vec++; if (err_bad_ctx !== 1'b1 || out_valid !== 1'b0) begin miss++; $display("FAIL bad_ctx%0d err/valid got %b/%b exp 1/0", cx[c], err_bad_ctx, out_valid); end
      @(negedge clk);
      vec++; if (err_bad_ctx !== 1'b0 || out_valid !== 1'b0) begin miss++; $display("FAIL bad_ctx%0d_pulse err/valid got %b/%b exp 0/0", cx[c], err_bad_ctx, out_valid); end
    end
    send(mk(1'b0, 9'd0, 9'o123, 9'd1, 8'd0, 8'd0, 2'd0, 4'h0, 32'h0));
    vec++; if (err_bad_ctx !== 1'b0 || out_valid !== 1'b0) begin miss++; $display("FAIL invalid_flit err/valid got %b/%b exp 0/0", err_bad_ctx, out_valid); end
  endtask

  task automatic test_snapshot;
    logic [85:0] e;
    in_flit = mk(1'b1, 9'd0, 9'd0, 9'd0, 8'd0, 8'h01, 2'd0, 4'h2, 32'haaaa5555);
    in_valid = 1'b1;
    cfg_we = 1'b1; cfg_ctx = 2'd0; cfg_slot = 4'd8; cfg_wdata = 18'(9'o055);
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0;
    e = {4'd3, mk(1'b1, 9'o011, 9'd0, 9'd5, 8'd0, 8'h01, 2'd0, 4'h2, 32'haaaa5555)};
    vec++; if (out_valid !== 1'b1 || out_flit !== e) begin miss++; $display("FAIL snap_old_parent got %b/%h exp 1/%h", out_valid, out_flit, e); end
    @(negedge clk);
    send(mk(1'b1, 9'd0, 9'd0, 9'd0, 8'd0, 8'h02, 2'd0, 4'h2, 32'h5555aaaa));
    e = {4'd3, mk(1'b1, 9'o055, 9'd0, 9'd5, 8'd0, 8'h02, 2'd0, 4'h2, 32'h5555aaaa)};
    vec++; if (out_valid !== 1'b1 || out_flit !== e) begin miss++; $display("FAIL snap_new_parent got %b/%h exp 1/%h", out_valid, out_flit, e); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [85:0] e;
    send(mk(1'b1, 9'd0, 9'o123, 9'd4, 8'd0, 8'h11, 2'd1, 4'h9, 32'h0));
    @(negedge clk);
    e = {4'd3, mk(1'b1, 9'o001, 9'o123, 9'd4, 8'd0, 8'h11, 2'd1, 4'h9, 32'h0)};
    vec++; if (out_valid !== 1'b1 || out_flit !== e) begin miss++; $display("FAIL mid_copy1 got %b/%h exp 1/%h", out_valid, out_flit, e); end
    rst = 1'b1;
    @(negedge clk);
    vec++; if (out_valid !== 1'b0 || out_flit !== '0) begin miss++; $display("FAIL mid_rst_abort got %b/%h exp 0/0", out_valid, out_flit); end
    rst = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      send(mk(1'b1, 9'd0, 9'o123, 9'd1, 8'(c), 8'd0, 2'd0, 4'h0, 32'h0));
      vec++; if (err_bad_ctx !== 1'b1 || out_valid !== 1'b0) begin miss++; $display("FAIL cleared_ctx%0d err/valid got %b/%b exp 1/0", c, err_bad_ctx, out_valid); end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_uptree;
    test_bcast;
    test_back_to_back_ring;
    test_recdbl;
    test_errors;
    test_snapshot;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/coll_dest_sequencer.md
# coll_dest_sequencer

Parametrised collective-routing stage between the router injection/ejection port and the reduction table. It accepts one collective flit at a time and looks up the flit's communicator in a runtime-programmable communicator table. It then emits one or more copies of the flit, each carrying a computed destination, for four algorithms: uptree, tree broadcast, ring and recursive doubling. Each outgoing flit has the communicator's child count appended for downstream reduction bookkeeping.

## Interface
Flit layout, LSB first: payload, op(4), algtype(2), tag(8), contextId(8), rank(RankWidth), src(AddrW), dst(AddrW), valid(1).
- Derived widths: AddrW = 3*CoordWidth; FanW = clog2(MaxFanout+1); FlitWidth = PayloadWidth+22+RankWidth+2*AddrW+1, which is 82 at defaults.

Parameters:
- PayloadWidth, 32, payload bits
- CoordWidth, 3, bits per x/y/z coordinate
- RankWidth, 9, rank field width
- CtxEntries, 4, communicator table depth
- MaxFanout, 8, child/partner slots per entry
- MyAddr, 0, this node's {z,y,x} address (AddrW bits)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_flit  in  FlitWidth  incoming flit
- in_valid  in  1  in_flit present
- in_ready  out  1  flit accepted when in_valid&in_ready
- out_flit  out  FlitWidth+FanW  {children, flit}
- out_valid  out  1  out_flit present
- out_ready  in  1  consumer takes out_flit
- cfg_we  in  1  table write strobe
- cfg_ctx  in  clog2(CtxEntries)  entry index
- cfg_slot  in  clog2(MaxFanout+3)  field select
- cfg_wdata  in  RankWidth+2*FanW+1  write data
- err_bad_ctx  out  1  one-cycle pulse on dropped flit

## Operation
- Table entry fields: entry_valid, local_rank, num_children, lg_commsize, parent, ring_next, slot[0..MaxFanout-1].
- Config slot mapping:
  - slot < MaxFanout writes slot[cfg_slot] from cfg_wdata[AddrW-1:0].
  - slot = MaxFanout writes parent.
  - slot = MaxFanout+1 writes ring_next.
  - slot = MaxFanout+2 writes header {entry_valid, lg_commsize, num_children, local_rank}, MSB first.
  - Other slot values are ignored.
- Reset clears all entries; entry_valid = 0 everywhere.
- On accept, the entry is snapshotted into working registers. A cfg write in the same cycle, or any later cycle, does not affect the packet in flight.
- local = (in_flit.src == MyAddr).
- Drop rules:
  - Flit valid bit = 0: consumed silently.
  - contextId >= CtxEntries, or entry_valid = 0: consumed, no output, err_bad_ctx = 1 the next cycle.
- Every emitted copy carries the input payload, op, algtype and src unchanged.
  - rank = local_rank if local, else the input rank.
  - children = num_children.
  - Valid bit = 1.
- Destinations by algtype:
  - algtype 0, uptree: one copy. dst = MyAddr if local_rank == 0, else parent.
  - algtype 1, tree broadcast:
    - A guest flit first emits one copy to MyAddr, then one copy to each of slot[0..num_children-1] in order.
    - A local flit emits to the children only.
    - A local flit with num_children = 0 emits one copy to MyAddr.
  - algtype 2, ring: tag is the remaining hop count.
    - tag == 0: one copy to MyAddr.
    - Otherwise: one copy to ring_next with tag-1.
  - algtype 3, recursive doubling:
    - d = |rank - local_rank|, computed at RankWidth+1 bits.
    - start = 0 if local, else bit-length(d) (0 for d = 0).
    - Emit to slot[start..lg_commsize-1] in ascending order.
    - A guest flit also emits a final copy to MyAddr.
    - If start >= lg_commsize, emit only the MyAddr copy.
- num_children and lg_commsize are clamped to MaxFanout.

## Timing
- States:
  - IDLE: no output pending.
  - EMIT: holding copy k of n.
- Transitions:
  - IDLE -> EMIT on accept with n >= 1.
  - EMIT stays in EMIT and increments k on out_ready when k < n-1.
  - On out_ready with k = n-1, EMIT -> IDLE, or restarts EMIT if a new flit is accepted in the same cycle.
- in_ready = !rst & (state == IDLE | (out_ready & k == n-1)). This gives back-to-back throughput.
- Latency: a flit accepted in cycle N has its first copy on out_valid in cycle N+1.
- out_flit is stable while out_valid=1 & out_ready=0.
- A flit is never split across contexts: the snapshot is held until its last copy is taken.
- Reset values:
  - out_valid = 0, out_flit = 0, err_bad_ctx = 0, state = IDLE, k = 0.
  - in_ready = 0 during rst.
- rst mid-sequence aborts all remaining copies and clears the table.

## Test plan
- Uptree: write ctx0 header {1, 3, 3, rank 5}, parent = 9'o011. Send a local flit with algtype 0 -> exactly one copy, dst = 9'o011, rank = 5, children = 3, appearing in the cycle after accept.
- Broadcast: ctx0 with 3 children at slots 9'o001/9'o002/9'o004. Send a guest flit -> 4 copies in order MyAddr, 001, 002, 004. out_ready is held low 3 cycles on copy 2, and out_flit must stay stable.
- Ring: tag = 2 -> one copy to ring_next with tag 1. tag = 0 -> one copy to MyAddr with tag 0.
- Recursive doubling: lg_commsize = 3, local_rank = 0.
  - Guest rank = 2 (d = 2, start = 2) -> copies to slot[2], then MyAddr.
  - Local flit -> copies to slot[0], slot[1], slot[2].
- Errors and drops: contextId = 7, or an entry with entry_valid = 0 -> no output, err_bad_ctx pulses for 1 cycle. A flit with valid bit = 0 -> no output, no error.
- Snapshot and reset:
  - cfg write to parent in the same cycle as an uptree accept -> the copy uses the old parent.
  - rst asserted during copy 2 of 4 -> out_valid = 0 the next cycle, and all entries read back invalid.
